// File: rtl/point_test_rx_responder_multi.sv
// point_test_rx_responder_multi: RX responder for the TX-initiated point test
// with multi-iteration sticky per-lane result accumulation and wait-state timeout.
module point_test_rx_responder_multi #(
  parameter int N_LANES     = 16,
  parameter int MAX_ITER    = 8,
  parameter int TIMEOUT_CYC = 8000,
  parameter int TO_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_mainband_or_valtrain_test,
  input  logic               i_lfsr_or_perlane,
  input  logic               i_valid_tx,
  input  logic               i_busy_negedge_detected,
  input  logic [3:0]         i_sideband_message,
  input  logic               i_sideband_message_valid,
  input  logic [N_LANES-1:0] i_comparison_results,
  input  logic               i_valid_result,
  output logic [3:0]         o_sideband_message,
  output logic [N_LANES-1:0] o_sideband_data,
  output logic               o_msg_info,
  output logic               o_valid_rx,
  output logic               o_data_valid,
  output logic [1:0]         o_mainband_pattern_compartor_cw,
  output logic               o_comparison_valid_en,
  output logic               o_test_ack_rx,
  output logic               o_timeout,
  output logic [3:0]         o_iter_count
);
  typedef enum logic [3:0] {
    IDLE, WAIT_TEST_REQ, WAIT_CLR_REQ, CLR_RESP, WAIT_RESULT_REQ,
    WAIT_NEXT_REQ, END_RESP, FINISH, TIMEOUT
  } state_t;
  state_t state, state_n;
  logic [3:0] msg, msg_n, iter, iter_n, req;
  logic [N_LANES-1:0] data, data_n, acc, acc_n;
  logic info, info_n, vrx, vrx_n, dv, dv_n, cve, cve_n, ack, ack_n, tmo, tmo_n;
  logic pend, pend_n, post, clr, waiting, sent;
  logic [1:0] cw, cw_n;
  logic [TO_W-1:0] cnt, cnt_n;
  always_comb begin
    state_n = state;
    msg_n = msg;
    data_n = data;
    acc_n = acc;
    info_n = info;
    cw_n = cw;
    cve_n = cve;
    ack_n = ack;
    tmo_n = tmo;
    iter_n = iter;
    cnt_n = '0;
    post = 1'b0;
    req = i_sideband_message_valid ? i_sideband_message : 4'b0000;
    sent = vrx & i_busy_negedge_detected;
    waiting = state inside {WAIT_TEST_REQ, WAIT_CLR_REQ, WAIT_RESULT_REQ, WAIT_NEXT_REQ};
    clr = req == 4'b0011 &&
          (state == WAIT_CLR_REQ || (state == WAIT_NEXT_REQ && iter < 4'(MAX_ITER)));
    if (state == IDLE && i_en) state_n = WAIT_TEST_REQ;
    if (state == WAIT_TEST_REQ && req == 4'b0001) begin
      state_n = WAIT_CLR_REQ;
      msg_n = 4'b0010;
      acc_n = '1;
      iter_n = '0;
      post = 1'b1;
    end
    if (clr) begin
      state_n = CLR_RESP;
      msg_n = 4'b0100;
      cw_n = i_mainband_or_valtrain_test ? 2'b00 : 2'b01;
      post = 1'b1;
    end
    // Response states leave on the edge where o_valid_rx drops
    if (state == CLR_RESP && sent) begin
      state_n = WAIT_RESULT_REQ;
      cw_n = i_mainband_or_valtrain_test ? 2'b00 : {1'b1, i_lfsr_or_perlane};
      cve_n = i_mainband_or_valtrain_test;
    end
    if (state == WAIT_RESULT_REQ && req == 4'b0101) begin
      state_n = WAIT_NEXT_REQ;
      msg_n = 4'b0110;
      cw_n = 2'b00;
      cve_n = 1'b0;
      info_n = i_valid_result;
      iter_n = iter < 4'(MAX_ITER) ? iter + 4'd1 : iter;
      data_n = i_valid_result ? acc & i_comparison_results : acc;
      acc_n = data_n;
      post = 1'b1;
    end
    if (state == WAIT_NEXT_REQ && req == 4'b0111) begin
      state_n = END_RESP;
      msg_n = 4'b1000;
      info_n = 1'b0;
      post = 1'b1;
    end
    if (state == END_RESP && sent) begin
      state_n = FINISH;
      ack_n = 1'b1;
    end
    if (waiting && state_n == state) begin
      if (cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        state_n = TIMEOUT;
        tmo_n = 1'b1;
        cw_n = 2'b00;
        cve_n = 1'b0;
      end else cnt_n = cnt + TO_W'(1);
    end
    // A post waits while the TX requester owns the sideband; busy wins over raising valid
    pend_n = post | (pend & (i_valid_tx | i_busy_negedge_detected));
    vrx_n = i_busy_negedge_detected ? 1'b0 : vrx | (pend & ~i_valid_tx);
    dv_n = vrx_n & (msg_n == 4'b0110);
    if (!i_en) begin
      state_n = IDLE;
      msg_n = '0;
      data_n = '0;
      acc_n = '1;
      info_n = 1'b0;
      cw_n = 2'b00;
      cve_n = 1'b0;
      ack_n = 1'b0;
      tmo_n = 1'b0;
      iter_n = '0;
      cnt_n = '0;
      pend_n = 1'b0;
      vrx_n = 1'b0;
      dv_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      msg <= '0;
      data <= '0;
      acc <= '1;
      info <= 1'b0;
      cw <= 2'b00;
      cve <= 1'b0;
      ack <= 1'b0;
      tmo <= 1'b0;
      iter <= '0;
      cnt <= '0;
      pend <= 1'b0;
      vrx <= 1'b0;
      dv <= 1'b0;
    end else begin
      state <= state_n;
      msg <= msg_n;
      data <= data_n;
      acc <= acc_n;
      info <= info_n;
      cw <= cw_n;
      cve <= cve_n;
      ack <= ack_n;
      tmo <= tmo_n;
      iter <= iter_n;
      cnt <= cnt_n;
      pend <= pend_n;
      vrx <= vrx_n;
      dv <= dv_n;
    end
  end
  assign o_sideband_message = msg;
  assign o_sideband_data = data;
  assign o_msg_info = info;
  assign o_valid_rx = vrx;
  assign o_data_valid = dv;
  assign o_mainband_pattern_compartor_cw = cw;
  assign o_comparison_valid_en = cve;
  assign o_test_ack_rx = ack;
  assign o_timeout = tmo;
  assign o_iter_count = iter;
endmodule

// File: tb/tb_point_test_rx_responder_multi.sv
// tb_point_test_rx_responder_multi: directed + randomized sideband partner with
// a transaction-level model of the sticky per-lane result accumulation.
module tb_point_test_rx_responder_multi;
  localparam int NL = 16;
  localparam int MI = 3;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_en = 1'b0;
  logic i_mainband_or_valtrain_test = 1'b0;
  logic i_lfsr_or_perlane = 1'b0;
  logic i_valid_tx = 1'b0;
  logic i_busy_negedge_detected = 1'b0;
  logic [3:0] i_sideband_message = '0;
  logic i_sideband_message_valid = 1'b0;
  logic [NL-1:0] i_comparison_results = '0;
  logic i_valid_result = 1'b0;
  logic [3:0] o_sideband_message;
  logic [NL-1:0] o_sideband_data;
  logic o_msg_info, o_valid_rx, o_data_valid, o_comparison_valid_en;
  logic o_test_ack_rx, o_timeout;
  logic [1:0] o_mainband_pattern_compartor_cw;
  logic [3:0] o_iter_count;
  logic [31:0] outs;
  int n_vec = 0;
  int n_err = 0;
  logic [NL-1:0] res_tab [MI];
  logic vr_tab [MI];

  point_test_rx_responder_multi #(.N_LANES(NL), .MAX_ITER(MI), .TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .i_mainband_or_valtrain_test(i_mainband_or_valtrain_test),
    .i_lfsr_or_perlane(i_lfsr_or_perlane), .i_valid_tx(i_valid_tx),
    .i_busy_negedge_detected(i_busy_negedge_detected),
    .i_sideband_message(i_sideband_message),
    .i_sideband_message_valid(i_sideband_message_valid),
    .i_comparison_results(i_comparison_results), .i_valid_result(i_valid_result),
    .o_sideband_message(o_sideband_message), .o_sideband_data(o_sideband_data),
    .o_msg_info(o_msg_info), .o_valid_rx(o_valid_rx), .o_data_valid(o_data_valid),
    .o_mainband_pattern_compartor_cw(o_mainband_pattern_compartor_cw),
    .o_comparison_valid_en(o_comparison_valid_en), .o_test_ack_rx(o_test_ack_rx),
    .o_timeout(o_timeout), .o_iter_count(o_iter_count)
  );

  always #5 clk = ~clk;
  assign outs = {o_sideband_message, o_sideband_data, o_msg_info, o_valid_rx, o_data_valid,
                 o_mainband_pattern_compartor_cw, o_comparison_valid_en, o_test_ack_rx,
                 o_timeout, o_iter_count};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] code);
    i_sideband_message = code;
    i_sideband_message_valid = 1'b1;
    @(negedge clk);
    i_sideband_message_valid = 1'b0;
    i_sideband_message = '0;
  endtask

  // Wait (bounded) for a response, check it, then play the sideband busy pulse
  task automatic resp(input string tag, input logic [3:0] code, input logic [NL-1:0] d,
                      input logic info);
    int k = 0;
    while (o_valid_rx !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".vld"}, o_valid_rx, 1);
    chk({tag, ".msg"}, o_sideband_message, code);
    chk({tag, ".dv"}, o_data_valid, code == 4'b0110);
    if (code == 4'b0110) chk({tag, ".data"}, {o_msg_info, o_sideband_data}, {info, d});
    if (code == 4'b1000) chk({tag, ".info"}, o_msg_info, 0);
    i_busy_negedge_detected = 1'b1;
    @(negedge clk);
    i_busy_negedge_detected = 1'b0;
    chk({tag, ".fall"}, {o_valid_rx, o_data_valid}, 0);
  endtask

  task automatic start(input string tag, input logic mb, input logic lfsr);
    i_mainband_or_valtrain_test = mb;
    i_lfsr_or_perlane = lfsr;
    i_en = 1'b1;
    @(negedge clk);
    req(4'b0001);
    resp({tag, ".test"}, 4'b0010, '0, 1'b0);
  endtask

  task automatic stop(input string tag);
    i_en = 1'b0;
    @(negedge clk);
    chk({tag, ".idle"}, outs, 0);
  endtask

  task automatic run_test(input string tag, input logic mb, input logic lfsr, input int iters);
    logic [NL-1:0] acc = '1;
    logic [NL-1:0] exp;
    start(tag, mb, lfsr);
    for (int it = 0; it < iters; it++) begin
      req(4'b0011);
      chk({tag, ".cw_clr"}, o_mainband_pattern_compartor_cw, mb ? 2'b00 : 2'b01);
      resp({tag, ".clr"}, 4'b0100, '0, 1'b0);
      chk({tag, ".cw_cmp"}, {o_mainband_pattern_compartor_cw, o_comparison_valid_en},
          mb ? 3'b001 : {1'b1, lfsr, 1'b0});
      i_comparison_results = res_tab[it];
      i_valid_result = vr_tab[it];
      req(4'b0101);
      chk({tag, ".cw_off"}, {o_mainband_pattern_compartor_cw, o_comparison_valid_en}, 0);
      exp = vr_tab[it] ? acc & res_tab[it] : acc;
      acc = exp;
      resp({tag, ".res"}, 4'b0110, exp, vr_tab[it]);
      chk({tag, ".iter"}, o_iter_count, it + 1);
    end
    if (iters == MI) begin
      req(4'b0011);
      repeat (3) @(negedge clk);
      chk({tag, ".sat"}, {o_valid_rx, o_sideband_message}, 5'b00110);
    end
    req(4'b0111);
    resp({tag, ".end"}, 4'b1000, '0, 1'b0);
    chk({tag, ".ack"}, {o_test_ack_rx, o_timeout, o_iter_count}, {2'b10, 4'(iters)});
    stop(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset", outs, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_en", outs, 0);

    res_tab[0] = 16'hFFFF; vr_tab[0] = 1'b1;
    run_test("mb1", 1'b0, 1'b0, 1);

    res_tab[0] = 16'hA5FF; res_tab[1] = 16'hFF0F; res_tab[2] = 16'hFFFF;
    vr_tab[0] = 1'b1; vr_tab[1] = 1'b1; vr_tab[2] = 1'b1;
    run_test("mb3", 1'b0, 1'b1, 3);

    res_tab[0] = 16'h1234; vr_tab[0] = 1'b0;
    run_test("vt", 1'b1, 1'b0, 1);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < MI; i++) begin
        res_tab[i] = NL'($urandom | $urandom);
        vr_tab[i] = 1'($urandom_range(0, 1));
      end
      run_test($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(1, MI));
    end

    i_mainband_or_valtrain_test = 1'b0;
    i_en = 1'b1;
    @(negedge clk);
    i_valid_tx = 1'b1;
    req(4'b0001);
    for (int i = 0; i < 5; i++) begin
      chk("vtx_hold", o_valid_rx, 0);
      @(negedge clk);
    end
    i_valid_tx = 1'b0;
    @(negedge clk);
    chk("vtx_rise", o_valid_rx, 1);
    resp("vtx", 4'b0010, '0, 1'b0);
    stop("vtx");

    start("to", 1'b0, 1'b0);
    req(4'b0011);
    resp("to.clr", 4'b0100, '0, 1'b0);
    chk("to.cw", o_mainband_pattern_compartor_cw, 2'b10);
    req(4'b0111);
    repeat (TO - 2) @(negedge clk);
    chk("to.before", o_timeout, 0);
    @(negedge clk);
    chk("to.fire", {o_timeout, o_mainband_pattern_compartor_cw, o_comparison_valid_en}, 4'b1000);
    repeat (3) @(negedge clk);
    chk("to.hold", o_timeout, 1);
    stop("to");

    start("tl", 1'b0, 1'b0);
    req(4'b0011);
    resp("tl.clr", 4'b0100, '0, 1'b0);
    repeat (TO - 1) @(negedge clk);
    i_comparison_results = 16'hFFFF;
    i_valid_result = 1'b1;
    req(4'b0101);
    chk("tl.no_to", o_timeout, 0);
    resp("tl.res", 4'b0110, 16'hFFFF, 1'b1);
    stop("tl");

    start("en", 1'b0, 1'b1);
    req(4'b0011);
    stop("en_clr");

    start("rs", 1'b0, 1'b1);
    req(4'b0011);
    resp("rs.clr", 4'b0100, '0, 1'b0);
    chk("rs.cw", o_mainband_pattern_compartor_cw, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("rs.reset", outs, 0);
    rst = 1'b0;
    i_en = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
